// File: rtl/norm_pkg.sv
// Shared definitions for the multiplier mantissa normalizer: default
// datapath geometry and the FSM state encoding.
package norm_pkg;

    localparam int DEF_WIDTH   = 49;
    localparam int DEF_SHAMT_W = 9;
    localparam int DEF_STEP    = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_SHIFT = S_SHIFT,
        ST_DONE  = S_DONE
    } state_t;

endpackage

// File: rtl/norm_step_shift.sv
// One normalization decision per cycle: zero detect, MSB set, limit hit,
// coarse STEP-bit shift, or single-bit shift, in that priority order.
module norm_step_shift
    import norm_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W,
    parameter int STEP    = DEF_STEP
) (
    input  logic [WIDTH-1:0]   data,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [SHAMT_W-1:0] limit,
    output logic [WIDTH-1:0]   next_data,
    output logic [SHAMT_W-1:0] next_shamt,
    output logic               done,
    output logic               zero,
    output logic               limited
);

    // One extra bit so the coarse-step bound check can never wrap.
    logic [SHAMT_W:0] coarse_sum;
    assign coarse_sum = {1'b0, shamt} + (SHAMT_W+1)'(STEP);

    // Priority-ordered shift decision; a coarse step is only taken when it
    // cannot pass the MSB (top STEP bits zero) and cannot pass the limit.
    always_comb begin
        next_data  = data;
        next_shamt = shamt;
        done       = 1'b0;
        zero       = 1'b0;
        limited    = 1'b0;
        if (data == '0) begin
            next_data  = '0;
            next_shamt = '0;
            done       = 1'b1;
            zero       = 1'b1;
        end else if (data[WIDTH-1]) begin
            done = 1'b1;
        end else if (shamt == limit) begin
            done    = 1'b1;
            limited = 1'b1;
        end else if ((data[WIDTH-1 -: STEP] == '0) && (coarse_sum <= {1'b0, limit})) begin
            next_data  = data << STEP;
            next_shamt = shamt + SHAMT_W'(STEP);
        end else begin
            next_data  = data << 1;
            next_shamt = shamt + SHAMT_W'(1);
        end
    end

endmodule

// File: rtl/seq_normalizer.sv
// Handshaked sequential mantissa normalizer. Left-shifts the operand until
// the MSB is set, the operand is zero, or the caller's limit is reached.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | waiting for an operand, outputs hold last result
//   ST_SHIFT | one shift decision per cycle on the working registers
//   ST_DONE  | result presented with out_valid until out_ready
module seq_normalizer
    import norm_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W,
    parameter int STEP    = DEF_STEP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_limit,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SHAMT_W-1:0] out_shamt,
    output logic               out_zero,
    output logic               out_limited
);

    localparam logic [SHAMT_W-1:0] LIM_MAX = SHAMT_W'(WIDTH-1);

    state_t             state;
    logic [WIDTH-1:0]   data_q;
    logic [SHAMT_W-1:0] shamt_q;
    logic [SHAMT_W-1:0] limit_q;

    logic [WIDTH-1:0]   step_data;
    logic [SHAMT_W-1:0] step_shamt;
    logic               step_done;
    logic               step_zero;
    logic               step_limited;

    logic               accept;
    logic [SHAMT_W-1:0] limit_clamped;

    // Ready in IDLE, or in DONE when the current result leaves this cycle;
    // held low throughout reset.
    assign in_ready      = !rst && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
    assign accept        = in_valid && in_ready;
    assign limit_clamped = (in_limit > LIM_MAX) ? LIM_MAX : in_limit;

    norm_step_shift #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W),
        .STEP    (STEP)
    ) u_step (
        .data       (data_q),
        .shamt      (shamt_q),
        .limit      (limit_q),
        .next_data  (step_data),
        .next_shamt (step_shamt),
        .done       (step_done),
        .zero       (step_zero),
        .limited    (step_limited)
    );

    // FSM, working registers and registered result; a same-cycle accept
    // overrides the DONE->IDLE exit so back-to-back operands go straight
    // to SHIFT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            data_q      <= '0;
            shamt_q     <= '0;
            limit_q     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_shamt   <= '0;
            out_zero    <= 1'b0;
            out_limited <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_IDLE;
                end
                ST_SHIFT: begin
                    if (step_done) begin
                        out_data    <= step_data;
                        out_shamt   <= step_shamt;
                        out_zero    <= step_zero;
                        out_limited <= step_limited;
                        out_valid   <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        data_q  <= step_data;
                        shamt_q <= step_shamt;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (accept) begin
                data_q      <= in_data;
                shamt_q     <= '0;
                limit_q     <= limit_clamped;
                out_zero    <= 1'b0;
                out_limited <= 1'b0;
                state       <= ST_SHIFT;
            end
        end
    end

endmodule

// File: tb/tb_seq_normalizer.sv
// Scoreboard bench for seq_normalizer: accepted operands are pushed with a
// reference result and expected latency; a monitor checks every valid
// output cycle against the queue head.
module tb_seq_normalizer;

    localparam int W  = 49;
    localparam int SW = 9;
    localparam int ST = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [SW-1:0] in_limit = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [SW-1:0] out_shamt;
    logic          out_zero;
    logic          out_limited;

    typedef struct {
        logic [W-1:0]  data;
        logic [SW-1:0] shamt;
        logic          zero;
        logic          limited;
        int            k;
        int            acc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   seen = 1'b0;
    int   ready_mode = 1;

    seq_normalizer dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_limit    (in_limit),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_shamt   (out_shamt),
        .out_zero    (out_zero),
        .out_limited (out_limited)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: final shift is min(leading zeros, clamped limit); each
    // cycle moves STEP bits while a full STEP fits, then single bits.
    function automatic exp_t model(input logic [W-1:0] d, input logic [SW-1:0] lim_in, input int acc);
        exp_t e;
        int lim;
        int lz;
        int t;
        lim = (int'(lim_in) > W-1) ? W-1 : int'(lim_in);
        lz = 0;
        while (lz < W && d[W-1-lz] == 1'b0) lz++;
        e.acc = acc;
        if (d == '0) begin
            e.data = '0;
            e.shamt = '0;
            e.zero = 1'b1;
            e.limited = 1'b0;
            e.k = 0;
        end else begin
            t = (lz < lim) ? lz : lim;
            e.data = d << t;
            e.shamt = SW'(t);
            e.zero = 1'b0;
            e.limited = (lz > lim);
            e.k = t / ST + t % ST;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Input side: record every handshake with its reference result.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready)
            sb.push_back(model(in_data, in_limit, cyc));
    end

    // Output side: latency on first valid cycle, value on every valid cycle
    // (covers stability under backpressure), pop on handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            seen = 1'b0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: data=%h shamt=%0d with empty queue", out_data, out_shamt);
            end else begin
                e = sb[0];
                if (!seen) begin
                    n_cmp++;
                    if (cyc != e.acc + 2 + e.k) begin
                        n_err++;
                        $display("FAIL latency: valid at %0d expected %0d", cyc, e.acc + 2 + e.k);
                    end
                    seen = 1'b1;
                end
                n_cmp++;
                if ({out_data, out_shamt, out_zero, out_limited} !== {e.data, e.shamt, e.zero, e.limited}) begin
                    n_err++;
                    $display("FAIL result: got data=%h shamt=%0d z=%b l=%b expected data=%h shamt=%0d z=%b l=%b",
                             out_data, out_shamt, out_zero, out_limited, e.data, e.shamt, e.zero, e.limited);
                end
                if (out_ready) begin
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [W-1:0] d, input logic [SW-1:0] l);
        int  b;
        bit  ok;
        @(posedge clk);
        #1;
        in_data = d;
        in_limit = l;
        in_valid = 1'b1;
        b = 0;
        ok = 1'b0;
        while (!ok && b < 500) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            b++;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: in_ready stayed %b", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int b;
        b = 0;
        @(negedge clk);
        while ((sb.size() != 0 || out_valid) && b < 2000) begin
            @(negedge clk);
            b++;
        end
        if (b >= 2000) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: queue=%0d out_valid=%b", sb.size(), out_valid);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_out_data"}, 64'(out_data), 64'd0);
        chk({tag, "_out_shamt"}, 64'(out_shamt), 64'd0);
        chk({tag, "_flags"}, 64'({out_zero, out_limited}), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] one;
        logic [63:0]  r;
        int           b;
        one = W'(1);

        #2 rst = 1'b1;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        ready_mode = 1;
        out_ready = 1'b1;
        send(one << 48, 9'd48);
        send(one, 9'd48);
        send(one << 40, 9'd5);
        send('0, 9'd48);
        send(one << 30, 9'd0);
        send(one << 10, 9'd511);
        send(one << 44, 9'd3);
        drain();

        // Backpressure then same-cycle release and accept.
        out_ready = 1'b0;
        send(one << 30, 9'd48);
        b = 0;
        @(negedge clk);
        while (!out_valid && b < 100) begin
            @(negedge clk);
            b++;
        end
        chk("bp_valid_seen", 64'(out_valid), 64'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_data = one << 47;
        in_limit = 9'd48;
        in_valid = 1'b1;
        @(negedge clk);
        chk("b2b_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();

        // Abort mid-shift.
        send(one, 9'd48);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("abort");
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        send(one << 48, 9'd48);
        drain();

        // Randomized traffic with random backpressure.
        ready_mode = 0;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            r = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0)
                send('0, SW'($urandom_range(0, 511)));
            else if ($urandom_range(0, 3) == 0)
                send(r[W-1:0] >> $urandom_range(0, W-1), SW'($urandom_range(0, 511)));
            else
                send(r[W-1:0] >> $urandom_range(0, W-1), SW'($urandom_range(0, 60)));
        end
        ready_mode = 1;
        out_ready = 1'b1;
        drain();
        chk("queue_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_normalizer.md
Name: seq_normalizer

Overview:
Clocked, parametrised mantissa normalizer for the fused array multiplier datapath. It left-shifts an unnormalised product until the MSB is set, a zero is detected, or a caller-supplied shift limit is reached, and reports the shift amount to the exponent adjuster. It supersedes the combinational shift loop with a bounded, handshaked FSM. It skips zero nibbles at STEP bits per cycle and supports a limit for denormal results.

Parameters:
WIDTH, 49, mantissa/product width in bits.
SHAMT_W, 9, width of the shift-amount and limit fields; must satisfy 2**SHAMT_W > WIDTH.
STEP, 4, coarse shift distance per cycle when the top STEP bits are all zero; 1 <= STEP < WIDTH.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  input operand valid.
in_ready  output  1  block can accept an operand.
in_data  input  WIDTH  unnormalised mantissa.
in_limit  input  SHAMT_W  maximum permitted left shift.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
out_data  output  WIDTH  normalised (or limit-stopped) mantissa.
out_shamt  output  SHAMT_W  total left shift applied.
out_zero  output  1  input was all zeros.
out_limited  output  1  stopped on limit before MSB set.

Behaviour:
- Single clock domain: clk. Reset rst is asynchronous and active-high.
- While rst is high: state=IDLE; out_valid=0; out_data=0; out_shamt=0; out_zero=0; out_limited=0; in_ready=0. Asserting rst mid-operation aborts the operation and discards it. The first accept is possible in the first cycle after rst deasserts.
- States: IDLE, SHIFT, DONE.
- in_ready is combinational: (state==IDLE) || (state==DONE && out_ready).
- Accept = in_valid && in_ready. On accept:
  - load data reg = in_data, shamt reg = 0;
  - limit reg = min(in_limit, WIDTH-1);
  - clear flags; go to SHIFT.
- SHIFT evaluates one priority-ordered decision per cycle:
  1. data==0: out_zero=1, shamt=0, data=0, go to DONE.
  2. data[WIDTH-1]==1: go to DONE, flags clear.
  3. shamt==limit: out_limited=1, go to DONE.
  4. data[WIDTH-1 -: STEP]==0 and shamt+STEP <= limit: data <<= STEP, shamt += STEP, stay in SHIFT.
  5. Otherwise: data <<= 1, shamt += 1, stay in SHIFT.
  - Shifts zero-fill from the LSB. The shamt adder is SHAMT_W+1 bits wide internally and cannot overflow.
- DONE: out_valid=1. out_data, out_shamt and flags are registered and held stable while out_valid && !out_ready.
  - out_ready=1 without a new accept: go to IDLE, out_valid=0 next cycle.
  - out_ready=1 with a same-cycle accept: go to SHIFT directly (back-to-back operation).
- Outputs keep their last values in IDLE. They are meaningful only while out_valid is high.
- Latency from accept at cycle N:
  - out_valid rises at N+2+k, where k is the number of shift cycles.
  - Already-normalised or zero input gives latency 2.
  - Worst case with limit WIDTH-1 is k <= ceil((WIDTH-1)/STEP)+STEP-1.
- A given input produces exactly one result; no result is dropped or duplicated under any out_ready pattern.
- in_limit=0 with nonzero input and MSB clear: result is the data unshifted, shamt=0, out_limited=1.
- out_zero and out_limited are never both 1.

Decomposition:
- Shared package norm_pkg holds:
  - state encoding localparams S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2;
  - default WIDTH/SHAMT_W/STEP constants for the multiplier.
- One combinational sub-module, norm_step_shift, contains rules 1–5 of the SHIFT decision.
  - Inputs: data, shamt, limit.
  - Outputs: next data, next shamt, done, zero, limited.
- The top module holds only the FSM, registers and handshake.

Test Plan:
- in_data=1<<48, in_limit=48, accept at cycle N -> out_valid at N+2; out_data=1<<48, out_shamt=0, out_zero=0, out_limited=0.
- in_data=1, in_limit=48 -> 12 coarse shifts; out_valid at N+14; out_data=1<<48, out_shamt=48, both flags 0.
- in_data=1<<40, in_limit=5 -> shift 4 then shift 1; out_data=1<<45, out_shamt=5, out_limited=1, out_valid at N+4.
- in_data=0, in_limit=48 -> out_valid at N+2; out_zero=1, out_data=0, out_shamt=0.
- Result 1 in DONE with out_ready=0 for 5 cycles -> outputs stable, in_ready=0. Then out_ready=1 with in_valid=1 (in_data=1<<47) in the same cycle -> accept that cycle; next result out_shamt=1 with out_valid at +3.
- rst pulsed during SHIFT of in_data=1 -> out_valid and all outputs 0 immediately with no clock edge. After release, a new operand 1<<48 yields out_shamt=0 with no trace of the aborted operation.
